// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 cache controller with a line-wide
// memory port. Tags, data and state bits live in flops.
module l1_dcache_ctrl #(
   parameter int NUM_LINES = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);
   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int TAG_W   = 28 - INDEX_W;

   typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_e;

   state_e state_q, state_d;

   logic [NUM_LINES-1:0]            valid_q, dirty_q;
   logic [NUM_LINES-1:0][TAG_W-1:0] tag_q;
   logic [NUM_LINES-1:0][127:0]     data_q;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [1:0]         off;
   logic               req, hit, fill, wr_hit, wb_done;

   assign idx     = proc_addr[INDEX_W+1:2];
   assign tag     = proc_addr[29:INDEX_W+2];
   assign off     = proc_addr[1:0];
   assign req     = proc_read | proc_write;
   assign hit     = valid_q[idx] && (tag_q[idx] == tag);
   assign fill    = (state_q == S_ALLOCATE) && mem_ready;
   assign wb_done = (state_q == S_WRITEBACK) && mem_ready;
   // read+write together is handled as a write
   assign wr_hit  = (state_q == S_COMPARE) && proc_write && hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_COMPARE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_COMPARE:   if (req && !hit) state_d = dirty_q[idx] ? S_WRITEBACK : S_ALLOCATE;
         S_WRITEBACK: if (mem_ready)   state_d = S_ALLOCATE;
         S_ALLOCATE:  if (mem_ready)   state_d = S_COMPARE;
         default:                      state_d = S_COMPARE;
      endcase
   end

   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         S_WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {tag_q[idx], idx};
            mem_wdata = data_q[idx];
         end
         S_ALLOCATE: begin
            mem_read = 1'b1;
            mem_addr = proc_addr[29:2];
         end
         default: ;
      endcase
      proc_stall = req && !((state_q == S_COMPARE) && hit);
      proc_rdata = hit ? data_q[idx][{off, 5'b0} +: 32] : 32'h0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (wb_done) dirty_q[idx] <= 1'b0;
         if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (wr_hit) dirty_q[idx] <= 1'b1;
      end
   end

   // payload is only meaningful once valid is set, so it carries no reset
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= mem_rdata;
      end else if (wr_hit) begin
         data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
      end
   end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Randomized bench for l1_dcache_ctrl against a flat-array cache/memory reference model.
module tb_l1_dcache_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int vecs = 0;
   int errs = 0;

   l1_dcache_ctrl #(.NUM_LINES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // reference model: cache contents plus backing memory keyed by line address
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag   [8];
   logic [127:0] m_data  [8];
   logic [127:0] bmem [logic [27:0]];

   function automatic logic [127:0] memline(input logic [27:0] la);
      if (bmem.exists(la)) return bmem[la];
      return {{4'hD, la}, {4'hC, la}, {4'hB, la}, {4'hA, la}};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
   endtask

   task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                         input logic [31:0] wd, input int wlat, input int alat);
      int          li, stalls, cnt, exp_stalls;
      bit          exp_hit, exp_wb, done, both, wb_seen, rd_seen;
      logic [27:0] exp_wb_addr, wb_addr, rd_addr;
      logic [127:0] exp_wb_data, wb_data;
      logic [31:0] exp_rdata, got_rdata;
      li          = int'(a[4:2]);
      exp_hit     = m_valid[li] && (m_tag[li] == a[29:5]);
      exp_wb      = !exp_hit && m_valid[li] && m_dirty[li];
      exp_wb_addr = {m_tag[li], a[4:2]};
      exp_wb_data = m_data[li];
      exp_stalls  = exp_hit ? 0 : (1 + (exp_wb ? wlat : 0) + alat);
      if (!exp_hit) begin
         if (exp_wb) bmem[exp_wb_addr] = m_data[li];
         m_data[li]  = memline(a[29:2]);
         m_tag[li]   = a[29:5];
         m_valid[li] = 1;
         m_dirty[li] = 0;
      end
      if (wr) begin
         m_data[li][32*int'(a[1:0]) +: 32] = wd;
         m_dirty[li] = 1;
      end
      exp_rdata = m_data[li][32*int'(a[1:0]) +: 32];

      @(negedge clk);
      proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
      stalls = 0; cnt = 0; done = 0; both = 0; wb_seen = 0; rd_seen = 0;
      wb_addr = '0; wb_data = '0; rd_addr = '0; got_rdata = '0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         #1;
         if (!proc_stall) begin
            done = 1;
            got_rdata = proc_rdata;
            break;
         end
         stalls++;
         if (mem_read && mem_write) both = 1;
         if (mem_write) begin
            if (!wb_seen) begin wb_seen = 1; wb_addr = mem_addr; wb_data = mem_wdata; cnt = 0; end
            cnt++;
            if (cnt == wlat) mem_ready = 1'b1;
         end else if (mem_read) begin
            if (!rd_seen) begin rd_seen = 1; rd_addr = mem_addr; cnt = 0; end
            cnt++;
            if (cnt == alat) begin
               mem_ready = 1'b1;
               mem_rdata = memline(a[29:2]);
            end
         end
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      proc_read = 1'b0; proc_write = 1'b0;

      vecs++;
      if (!done) begin
         errs++; $display("FAIL timeout addr=%h: stall never dropped", a);
      end
      vecs++;
      if (stalls != exp_stalls) begin
         errs++; $display("FAIL stall_cycles addr=%h: got %0d expected %0d", a, stalls, exp_stalls);
      end
      vecs++;
      if (both) begin
         errs++; $display("FAIL mem_rd_wr_both addr=%h: got 1 expected 0", a);
      end
      vecs++;
      if (wb_seen != exp_wb) begin
         errs++; $display("FAIL writeback_issued addr=%h: got %0d expected %0d", a, wb_seen, exp_wb);
      end
      if (exp_wb) begin
         vecs++;
         if (wb_addr !== exp_wb_addr) begin
            errs++; $display("FAIL wb_addr addr=%h: got %h expected %h", a, wb_addr, exp_wb_addr);
         end
         vecs++;
         if (wb_data !== exp_wb_data) begin
            errs++; $display("FAIL wb_data addr=%h: got %h expected %h", a, wb_data, exp_wb_data);
         end
      end
      vecs++;
      if (rd_seen != !exp_hit) begin
         errs++; $display("FAIL fetch_issued addr=%h: got %0d expected %0d", a, rd_seen, !exp_hit);
      end
      if (!exp_hit) begin
         vecs++;
         if (rd_addr !== a[29:2]) begin
            errs++; $display("FAIL fetch_addr addr=%h: got %h expected %h", a, rd_addr, a[29:2]);
         end
      end
      if (rd && !wr) begin
         vecs++;
         if (got_rdata !== exp_rdata) begin
            errs++; $display("FAIL rdata addr=%h: got %h expected %h", a, got_rdata, exp_rdata);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
      mem_ready = 0; mem_rdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      vecs++;
      if ({mem_read, mem_write, proc_stall} !== 3'b000) begin
         errs++; $display("FAIL reset_ctl: got %b expected 000", {mem_read, mem_write, proc_stall});
      end
      vecs++;
      if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
         errs++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
      end
      vecs++;
      if (proc_rdata !== 32'h0) begin
         errs++; $display("FAIL reset_rdata: got %h expected 0", proc_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vecs++;
      if (proc_stall !== 1'b0) begin
         errs++; $display("FAIL idle_stall: got %b expected 0", proc_stall);
      end
   endtask

   task automatic test_cold_read();
      bmem[28'h4] = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
      access(1, 0, 30'h10, 32'h0, 1, 3);
   endtask

   task automatic test_hit_read();
      access(1, 0, 30'h11, 32'h0, 1, 1);
   endtask

   task automatic test_write_hit();
      access(0, 1, 30'h12, 32'hDEADBEEF, 1, 1);
      access(1, 0, 30'h12, 32'h0, 1, 1);
   endtask

   task automatic test_ignore_ready();
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = {4{32'h5A5A5A5A}};
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      access(1, 0, 30'h12, 32'h0, 1, 1);
   endtask

   task automatic test_dirty_evict();
      access(1, 0, 30'h30, 32'h0, 2, 3);
   endtask

   task automatic test_write_miss();
      access(0, 1, 30'h08, 32'hCAFEF00D, 1, 2);
      access(1, 0, 30'h28, 32'h0, 3, 1);
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 0;
      @(negedge clk);
      proc_read = 1'b1; proc_addr = 30'h10;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mem_read) begin seen = 1; break; end
         @(negedge clk);
      end
      vecs++;
      if (!seen) begin
         errs++; $display("FAIL reset_mid_alloc: mem_read got 0 expected 1");
      end
      rst_n = 1'b0;
      #1;
      vecs++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errs++; $display("FAIL reset_mid_drop: got rd=%b wr=%b expected 0/0", mem_read, mem_write);
      end
      proc_read = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      access(1, 0, 30'h10, 32'h0, 1, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic [29:0] a;
         int op;
         a  = {23'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 9);
         access(op < 5, op >= 5, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
         if (op == 9) access(1, 1, a ^ 30'h1, $urandom, 2, 2);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int o = 0; o < 4; o++) access(1, 0, {28'h7, 2'(o)}, 32'h0, 1, 1);
      for (int o = 0; o < 4; o++) access(0, 1, {28'h7, 2'(o)}, 32'h1000 + o, 1, 1);
      for (int o = 0; o < 4; o++) access(1, 0, {28'h7, 2'(o)}, 32'h0, 1, 1);
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_hit_read();
      test_write_hit();
      test_ignore_ready();
      test_dirty_evict();
      test_write_miss();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
